// File: rtl/cache_alloc_pkg.sv
// Shared types and helpers for the miss-side way allocator.
// Way counts up to 64 are supported by the index helper.
package cache_alloc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    COMMIT    = 3'd4
  } alloc_state_e;

  function automatic logic [5:0] onehot_to_idx(input logic [63:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/first_one_encoder.sv
// Lowest-set-bit priority encoder: binary index of the first 1 plus a found flag.
// Purely combinational; index is 0 when nothing is set.
module first_one_encoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         i_vec,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_found
);

  localparam int IDX_W = $clog2(WIDTH);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lru_victim_allocator.sv
// Miss allocation sequencer: picks a free or LRU victim, runs writeback/fill, re-ages the policy.
// Owns per-way valid/dirty state; every output comes straight from a register.
module lru_victim_allocator
  import cache_alloc_pkg::*;
#(
  parameter int NUM_WAYS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        miss_req,
  input  logic                        miss_is_write,
  output logic                        miss_ack,
  input  logic                        hit_valid,
  input  logic [NUM_WAYS-1:0]         hit_way,
  input  logic                        hit_is_write,
  input  logic                        inv_valid,
  input  logic [NUM_WAYS-1:0]         inv_way,
  input  logic                        eviction_ready,
  input  logic [NUM_WAYS-1:0]         eviction_target,
  output logic [NUM_WAYS-1:0]         allocate_way,
  output logic                        wb_req,
  output logic [$clog2(NUM_WAYS)-1:0] wb_way,
  input  logic                        wb_ack,
  output logic                        fill_req,
  output logic [$clog2(NUM_WAYS)-1:0] fill_way,
  input  logic                        fill_ack,
  output logic                        alloc_done,
  output logic [$clog2(NUM_WAYS)-1:0] alloc_way_idx,
  output logic                        busy,
  output logic [NUM_WAYS-1:0]         valid_vec,
  output logic [NUM_WAYS-1:0]         dirty_vec
);

  localparam int WAY_IDX_W = $clog2(NUM_WAYS);

  alloc_state_e         r_state;
  logic                 r_busy, r_miss_ack, r_miss_wr, r_wb_req, r_fill_req, r_alloc_done;
  logic [WAY_IDX_W-1:0] r_victim, r_wb_way, r_fill_way, r_alloc_idx;
  logic [NUM_WAYS-1:0]  r_alloc_way, r_valid, r_dirty;

  logic [WAY_IDX_W-1:0] w_free_idx, w_evict_idx;
  logic                 w_free_found, w_evict_found, w_in_flight;
  logic [NUM_WAYS-1:0]  w_victim_oh, w_protect, w_hit_set, w_inv_clr, w_valid_nxt, w_dirty_nxt;

  first_one_encoder #(.WIDTH(NUM_WAYS)) u_free_enc (
    .i_vec   (~r_valid),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  first_one_encoder #(.WIDTH(NUM_WAYS)) u_evict_enc (
    .i_vec   (eviction_target),
    .o_idx   (w_evict_idx),
    .o_found (w_evict_found)
  );

  // Once a victim is latched, outside hits/invalidates must not disturb its state.
  assign w_in_flight = (r_state == WRITEBACK) || (r_state == FILL) || (r_state == COMMIT);
  assign w_victim_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << r_victim;
  assign w_protect   = w_in_flight ? w_victim_oh : '0;
  assign w_hit_set   = (hit_valid && hit_is_write) ? (hit_way & r_valid & ~w_protect) : '0;
  assign w_inv_clr   = inv_valid ? (inv_way & ~w_protect) : '0;

  always_comb begin
    w_valid_nxt = r_valid & ~w_inv_clr;
    w_dirty_nxt = (r_dirty | w_hit_set) & ~w_inv_clr;
    if (r_state == WRITEBACK && wb_ack) begin
      w_valid_nxt = w_valid_nxt & ~w_victim_oh;
      w_dirty_nxt = w_dirty_nxt & ~w_victim_oh;
    end
    if (r_state == COMMIT) begin
      w_valid_nxt = w_valid_nxt | w_victim_oh;
      w_dirty_nxt = r_miss_wr ? (w_dirty_nxt | w_victim_oh) : (w_dirty_nxt & ~w_victim_oh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_miss_ack   <= 1'b0;
      r_miss_wr    <= 1'b0;
      r_victim     <= '0;
      r_wb_req     <= 1'b0;
      r_wb_way     <= '0;
      r_fill_req   <= 1'b0;
      r_fill_way   <= '0;
      r_alloc_way  <= '0;
      r_alloc_done <= 1'b0;
      r_alloc_idx  <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
    end else begin
      r_miss_ack   <= 1'b0;
      r_alloc_done <= 1'b0;
      r_alloc_way  <= '0;
      r_valid      <= w_valid_nxt;
      r_dirty      <= w_dirty_nxt;
      case (r_state)
        IDLE: begin
          if (miss_req) begin
            r_miss_wr  <= miss_is_write;
            r_miss_ack <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SELECT;
          end
        end
        SELECT: begin
          if (w_free_found) begin
            r_victim   <= w_free_idx;
            r_fill_req <= 1'b1;
            r_fill_way <= w_free_idx;
            r_state    <= FILL;
          end else if (eviction_ready && w_evict_found) begin
            r_victim <= w_evict_idx;
            if (r_dirty[w_evict_idx]) begin
              r_wb_req <= 1'b1;
              r_wb_way <= w_evict_idx;
              r_state  <= WRITEBACK;
            end else begin
              r_fill_req <= 1'b1;
              r_fill_way <= w_evict_idx;
              r_state    <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (wb_ack) begin
            r_wb_req   <= 1'b0;
            r_fill_req <= 1'b1;
            r_fill_way <= r_victim;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (fill_ack) begin
            r_fill_req <= 1'b0;
            r_state    <= COMMIT;
          end
        end
        COMMIT: begin
          r_alloc_way  <= w_victim_oh;
          r_alloc_done <= 1'b1;
          r_alloc_idx  <= r_victim;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign miss_ack      = r_miss_ack;
  assign allocate_way  = r_alloc_way;
  assign wb_req        = r_wb_req;
  assign wb_way        = r_wb_way;
  assign fill_req      = r_fill_req;
  assign fill_way      = r_fill_way;
  assign alloc_done    = r_alloc_done;
  assign alloc_way_idx = r_alloc_idx;
  assign busy          = r_busy;
  assign valid_vec     = r_valid;
  assign dirty_vec     = r_dirty;

  a_evict_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    eviction_ready |-> $onehot(eviction_target));
  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    hit_valid |-> $onehot(hit_way));
  a_alloc_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(allocate_way));
  a_wb_fill_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_req && fill_req));
  a_victim_untouched: assert property (@(posedge clk) disable iff (!rst_n)
    w_in_flight |-> !((hit_valid && |(hit_way & w_victim_oh)) || (inv_valid && |(inv_way & w_victim_oh))));
  a_alloc_idx: assert property (@(posedge clk) disable iff (!rst_n)
    (|allocate_way) |-> (alloc_way_idx == WAY_IDX_W'(onehot_to_idx(64'(allocate_way)))));

endmodule

// File: tb/tb_lru_victim_allocator.sv
// Directed plus randomized bench for lru_victim_allocator with NUM_WAYS=4,
// checked against a transaction-level model of the set's valid/dirty state.
module tb_lru_victim_allocator;

  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_req, miss_is_write, miss_ack;
  logic          hit_valid, hit_is_write, inv_valid;
  logic [NW-1:0] hit_way, inv_way;
  logic          eviction_ready;
  logic [NW-1:0] eviction_target, allocate_way;
  logic          wb_req, wb_ack, fill_req, fill_ack, alloc_done, busy;
  logic [1:0]    wb_way, fill_way, alloc_way_idx;
  logic [NW-1:0] valid_vec, dirty_vec;

  int checks = 0;
  int errors = 0;
  int n;
  bit [NW-1:0] m_valid, m_dirty;

  lru_victim_allocator #(.NUM_WAYS(NW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_req        (miss_req),
    .miss_is_write   (miss_is_write),
    .miss_ack        (miss_ack),
    .hit_valid       (hit_valid),
    .hit_way         (hit_way),
    .hit_is_write    (hit_is_write),
    .inv_valid       (inv_valid),
    .inv_way         (inv_way),
    .eviction_ready  (eviction_ready),
    .eviction_target (eviction_target),
    .allocate_way    (allocate_way),
    .wb_req          (wb_req),
    .wb_way          (wb_way),
    .wb_ack          (wb_ack),
    .fill_req        (fill_req),
    .fill_way        (fill_way),
    .fill_ack        (fill_ack),
    .alloc_done      (alloc_done),
    .alloc_way_idx   (alloc_way_idx),
    .busy            (busy),
    .valid_vec       (valid_vec),
    .dirty_vec       (dirty_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Free way first (lowest index), otherwise whatever the policy names.
  function automatic int pick_victim(input int tgt);
    for (int i = 0; i < NW; i++) begin
      if (!m_valid[i]) return i;
    end
    return tgt;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, 32'(valid_vec), 32'(m_valid));
    chk({tag, "_dirty"}, 32'(dirty_vec), 32'(m_dirty));
  endtask

  task automatic do_touch(input bit hit_en, input bit hwr, input int hw, input bit inv_en, input int iw);
    hit_valid    = hit_en;
    hit_way      = NW'(1 << hw);
    hit_is_write = hwr;
    inv_valid    = inv_en;
    inv_way      = NW'(1 << iw);
    step();
    hit_valid = 1'b0;
    inv_valid = 1'b0;
    if (hit_en && hwr && m_valid[hw]) m_dirty[hw] = 1'b1;
    if (inv_en) begin
      m_valid[iw] = 1'b0;
      m_dirty[iw] = 1'b0;
    end
    check_state("touch");
  endtask

  task automatic do_miss(input bit wr, input bit rdy, input int tgt, input int wb_lat,
                         input int fill_lat, input int stall_inv, input bit hold_req, input int exp_lat);
    int k, v, lat, extra;
    miss_req        = 1'b1;
    miss_is_write   = wr;
    eviction_ready  = rdy;
    eviction_target = NW'(1 << tgt);
    k = 0;
    do begin step(); k++; end while (!miss_ack && k < 20);
    chk("miss_ack", 32'(miss_ack), 32'd1);
    lat   = k;
    extra = 0;
    if (!hold_req) miss_req = 1'b0;
    if (!rdy && m_valid == '1) begin
      repeat (5) begin
        step(); lat++;
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_idle_bus", 32'({wb_req, fill_req}), 32'd0);
      end
      inv_valid = 1'b1;
      inv_way   = NW'(1 << stall_inv);
      step(); lat++;
      inv_valid = 1'b0;
      m_valid[stall_inv] = 1'b0;
      m_dirty[stall_inv] = 1'b0;
    end
    v = pick_victim(tgt);
    k = 0;
    do begin
      step(); lat++; k++;
      if (miss_ack) extra++;
    end while (!wb_req && !fill_req && k < 20);
    if (m_dirty[v]) begin
      chk("wb_req", 32'(wb_req), 32'd1);
      chk("wb_way", 32'(wb_way), 32'(v));
      for (int i = 0; i < wb_lat; i++) begin
        step(); lat++;
        chk("wb_hold", 32'({wb_req, fill_req}), 32'b10);
        chk("wb_way_hold", 32'(wb_way), 32'(v));
      end
      wb_ack = 1'b1;
      step(); lat++;
      wb_ack = 1'b0;
      m_valid[v] = 1'b0;
      m_dirty[v] = 1'b0;
      chk("wb_drop", 32'(wb_req), 32'd0);
    end else begin
      chk("no_wb", 32'(wb_req), 32'd0);
    end
    chk("fill_req", 32'(fill_req), 32'd1);
    chk("fill_way", 32'(fill_way), 32'(v));
    if (hold_req) begin
      miss_req = 1'b0;
      chk("busy_no_reack", 32'(extra), 32'd0);
    end
    for (int i = 0; i < fill_lat; i++) begin
      step(); lat++;
      chk("fill_hold", 32'(fill_req), 32'd1);
    end
    fill_ack = 1'b1;
    step(); lat++;
    fill_ack = 1'b0;
    chk("fill_drop", 32'(fill_req), 32'd0);
    k = 0;
    while (!alloc_done && k < 10) begin step(); lat++; k++; end
    chk("alloc_done", 32'(alloc_done), 32'd1);
    chk("allocate_way", 32'(allocate_way), 32'(1 << v));
    chk("alloc_way_idx", 32'(alloc_way_idx), 32'(v));
    chk("busy_clear", 32'(busy), 32'd0);
    if (exp_lat > 0) chk("min_latency", 32'(lat), 32'(exp_lat));
    m_valid[v] = 1'b1;
    m_dirty[v] = wr;
    step();
    chk("alloc_pulse", 32'({alloc_done, allocate_way}), 32'd0);
    chk("idx_held", 32'(alloc_way_idx), 32'(v));
    check_state("miss");
  endtask

  initial begin
    rst_n           = 1'b0;
    miss_req        = 1'b0;
    miss_is_write   = 1'b0;
    hit_valid       = 1'b0;
    hit_way         = '0;
    hit_is_write    = 1'b0;
    inv_valid       = 1'b0;
    inv_way         = '0;
    eviction_ready  = 1'b0;
    eviction_target = '0;
    wb_ack          = 1'b0;
    fill_ack        = 1'b0;
    m_valid         = '0;
    m_dirty         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_vec), 32'd0);
    chk("rst_dirty", 32'(dirty_vec), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alloc_way", 32'(allocate_way), 32'd0);
    chk("rst_alloc_idx", 32'(alloc_way_idx), 32'd0);
    chk("rst_reqs", 32'({wb_req, fill_req, miss_ack, alloc_done}), 32'd0);
    chk("rst_ways", 32'({wb_way, fill_way}), 32'd0);
    rst_n = 1'b1;
    step();

    // Write hit to an invalid way must not mark it dirty.
    do_touch(1'b1, 1'b1, 2, 1'b0, 0);

    // Cold fill, policy not ready: free ways 0..3 in order, first at minimum latency.
    do_miss(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 4);
    do_miss(1'b0, 1'b0, 0, 0, 1, 0, 1'b0, 0);
    do_miss(1'b0, 1'b0, 0, 0, 1, 0, 1'b0, 0);
    do_miss(1'b0, 1'b0, 0, 0, 1, 0, 1'b0, 0);
    chk("cold_full", 32'(valid_vec), 32'hF);

    // Clean eviction of way 2.
    do_miss(1'b0, 1'b1, 2, 0, 1, 0, 1'b0, 0);

    // Dirty eviction of way 1; writeback held three cycles; line refilled clean.
    do_touch(1'b1, 1'b1, 1, 1'b0, 0);
    chk("dirty_way1", 32'(dirty_vec), 32'h2);
    do_miss(1'b0, 1'b1, 1, 2, 0, 0, 1'b0, 0);

    // Policy stalls; invalidate of way 3 frees a way.
    do_miss(1'b0, 1'b0, 0, 0, 0, 3, 1'b0, 0);

    // Invalidate beats write hit on the same way; then a held miss_req is acked once.
    do_touch(1'b1, 1'b1, 0, 1'b1, 0);
    do_miss(1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 0);

    // Reset mid-FILL abandons the sequence.
    miss_req        = 1'b1;
    miss_is_write   = 1'b0;
    eviction_ready  = 1'b1;
    eviction_target = 4'b0001;
    n = 0;
    do begin
      step(); n++;
      if (miss_ack) miss_req = 1'b0;
    end while (!fill_req && n < 10);
    miss_req = 1'b0;
    chk("pre_reset_fill", 32'(fill_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fill_req", 32'(fill_req), 32'd0);
    chk("arst_valid", 32'(valid_vec), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    m_valid = '0;
    m_dirty = '0;
    step();
    rst_n = 1'b1;
    step();
    do_miss(1'b1, 1'b1, 2, 0, 1, 0, 1'b0, 0);
    chk("restart_way0", 32'(alloc_way_idx), 32'd0);

    // Random mix of hits, invalidates, collisions and misses.
    for (int it = 0; it < 80; it++) begin
      int op, w;
      op = int'($urandom_range(0, 5));
      w  = int'($urandom_range(0, NW - 1));
      case (op)
        0: do_touch(1'b1, 1'($urandom_range(0, 1)), w, 1'b0, 0);
        1: do_touch(1'b0, 1'b0, 0, 1'b1, w);
        2: do_touch(1'b1, 1'b1, w, 1'b1, int'($urandom_range(0, NW - 1)));
        default: do_miss(1'($urandom_range(0, 1)), 1'b1, w, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), 0, 1'b0, 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
